// File: rtl/mem_arbiter.sv
`default_nettype none
//============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port, variable-latency memory between the
//            instruction-fetch stage and the MEM stage. One transaction is
//            in flight at a time and the data side wins when both are
//            pending. A combinational stall freezes every pipeline register
//            until all requests of the current cycle have completed, and a
//            saturating counter records the number of stalled cycles.
// Ports    : Clock_i, Reset_i      - clock, synchronous active-high reset
//            IReq_i, IAddr_i       - fetch request / address
//            IRdata_o              - fetched instruction (held until next fetch)
//            DRead_i, DWrite_i     - MEM-stage read / write request bits
//            DAddr_i, DWdata_i     - MEM-stage address / write data
//            DRdata_o              - load data (held until next data read)
//            MemEnable_o, MemWrite_o, MemAddr_o, MemWdata_o - memory request
//            MemRdata_i, MemAck_i  - memory read data / completion pulse
//            Stall_o               - global pipeline freeze
//            StallCycles_o         - saturating stalled-cycle count
// Revision : 1.0 - initial release
//============================================================================
module mem_arbiter (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic        IReq_i,
    input  logic [31:0] IAddr_i,
    output logic [31:0] IRdata_o,
    input  logic        DRead_i,
    input  logic        DWrite_i,
    input  logic [31:0] DAddr_i,
    input  logic [31:0] DWdata_i,
    output logic [31:0] DRdata_o,
    output logic        MemEnable_o,
    output logic        MemWrite_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemWdata_o,
    input  logic [31:0] MemRdata_i,
    input  logic        MemAck_i,
    output logic        Stall_o,
    output logic [31:0] StallCycles_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_D_ACC = 2'd1,
        S_I_ACC = 2'd2
    } state_t;

    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    state_t      r_state;
    logic        r_idone;
    logic        r_ddone;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_irdata;
    logic [31:0] r_drdata;
    logic [31:0] r_stall_cycles;

    logic        w_dreq;
    logic        w_ipend;
    logic        w_dpend;
    logic        w_stall;
    logic        w_ack;

    // A simultaneous read+write request is handled as a write, so the write
    // flag of the data side is simply DWrite_i.
    assign w_dreq  = DRead_i | DWrite_i;
    assign w_ipend = IReq_i & ~r_idone;
    assign w_dpend = w_dreq & ~r_ddone;
    assign w_stall = w_ipend | w_dpend;
    // Acks are only meaningful while a request is actually on the bus.
    assign w_ack   = MemAck_i & r_mem_en;

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            r_state        <= S_IDLE;
            r_idone        <= 1'b0;
            r_ddone        <= 1'b0;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= 32'd0;
            r_mem_wdata    <= 32'd0;
            r_irdata       <= 32'd0;
            r_drdata       <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (w_stall && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end

            // The pipeline advances on this edge, so the next cycle carries
            // fresh requests that have not been serviced yet.
            if (!w_stall) begin
                r_idone <= 1'b0;
                r_ddone <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_dpend) begin
                        r_state     <= S_D_ACC;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= DWrite_i;
                        r_mem_addr  <= DAddr_i;
                        r_mem_wdata <= DWdata_i;
                    end else if (w_ipend) begin
                        r_state    <= S_I_ACC;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= IAddr_i;
                    end
                end

                S_D_ACC: begin
                    if (w_ack) begin
                        r_ddone <= 1'b1;
                        if (!r_mem_we) begin
                            r_drdata <= MemRdata_i;
                        end
                        // Chain straight into the fetch with enable kept high
                        // so there is no bubble between the two accesses.
                        if (w_ipend) begin
                            r_state    <= S_I_ACC;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= IAddr_i;
                        end else begin
                            r_state  <= S_IDLE;
                            r_mem_en <= 1'b0;
                        end
                    end
                end

                S_I_ACC: begin
                    if (w_ack) begin
                        r_idone  <= 1'b1;
                        r_irdata <= MemRdata_i;
                        r_state  <= S_IDLE;
                        r_mem_en <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_mem_en <= 1'b0;
                end
            endcase
        end
    end

    assign IRdata_o      = r_irdata;
    assign DRdata_o      = r_drdata;
    assign MemEnable_o   = r_mem_en;
    assign MemWrite_o    = r_mem_we;
    assign MemAddr_o     = r_mem_addr;
    assign MemWdata_o    = r_mem_wdata;
    assign Stall_o       = w_stall;
    assign StallCycles_o = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. A small memory
//            model acks in the Nth cycle of MemEnable_o (N=1 is zero-wait)
//            and logs every accepted transaction.
// Revision : 1.0 - initial release
//============================================================================
module tb_mem_arbiter;

    logic        Clock_i = 1'b0;
    logic        Reset_i = 1'b1;
    logic        IReq_i = 1'b0;
    logic [31:0] IAddr_i = 32'd0;
    logic [31:0] IRdata_o;
    logic        DRead_i = 1'b0;
    logic        DWrite_i = 1'b0;
    logic [31:0] DAddr_i = 32'd0;
    logic [31:0] DWdata_i = 32'd0;
    logic [31:0] DRdata_o;
    logic        MemEnable_o;
    logic        MemWrite_o;
    logic [31:0] MemAddr_o;
    logic [31:0] MemWdata_o;
    logic [31:0] MemRdata_i = 32'd0;
    logic        MemAck_i = 1'b0;
    logic        Stall_o;
    logic [31:0] StallCycles_o;

    int n_checks = 0;
    int n_pass   = 0;

    // memory model controls and transaction log
    logic        mem_auto  = 1'b0;
    int          mem_lat   = 1;
    logic [31:0] mem_rdata = 32'd0;
    int          en_cnt    = 0;
    int          log_n     = 0;
    logic [31:0] log_addr  [8];
    logic        log_we    [8];
    logic [31:0] log_wdata [8];

    mem_arbiter dut (
        .Clock_i       (Clock_i),
        .Reset_i       (Reset_i),
        .IReq_i        (IReq_i),
        .IAddr_i       (IAddr_i),
        .IRdata_o      (IRdata_o),
        .DRead_i       (DRead_i),
        .DWrite_i      (DWrite_i),
        .DAddr_i       (DAddr_i),
        .DWdata_i      (DWdata_i),
        .DRdata_o      (DRdata_o),
        .MemEnable_o   (MemEnable_o),
        .MemWrite_o    (MemWrite_o),
        .MemAddr_o     (MemAddr_o),
        .MemWdata_o    (MemWdata_o),
        .MemRdata_i    (MemRdata_i),
        .MemAck_i      (MemAck_i),
        .Stall_o       (Stall_o),
        .StallCycles_o (StallCycles_o)
    );

    always #5 Clock_i = ~Clock_i;

    always @(posedge Clock_i) begin
        #1;
        if (mem_auto && MemEnable_o) begin
            en_cnt = en_cnt + 1;
            if (en_cnt >= mem_lat) begin
                MemAck_i   = 1'b1;
                MemRdata_i = mem_rdata;
                en_cnt     = 0;
                if (log_n < 8) begin
                    log_addr[log_n]  = MemAddr_o;
                    log_we[log_n]    = MemWrite_o;
                    log_wdata[log_n] = MemWdata_o;
                end
                log_n = log_n + 1;
            end else begin
                MemAck_i = 1'b0;
            end
        end else begin
            MemAck_i = 1'b0;
            en_cnt   = 0;
        end
    end

    task automatic step();
        @(posedge Clock_i);
        #2;
    endtask

    // Counts consecutive stalled cycles from the current one, bounded.
    task automatic count_stall(input int limit, output int stalls, output int en_cycles);
        stalls    = 0;
        en_cycles = 0;
        while (Stall_o === 1'b1 && stalls < limit) begin
            stalls++;
            if (MemEnable_o === 1'b1) en_cycles++;
            @(posedge Clock_i);
            #3;
        end
    endtask

    task automatic test_reset();
        Reset_i = 1'b1;
        step();
        step();
        Reset_i = 1'b0;
        #1;
        n_checks++; if (Stall_o !== 1'b0) $display("FAIL reset_stall: got %0b want 0", Stall_o); else n_pass++;
        n_checks++; if (MemEnable_o !== 1'b0 || MemWrite_o !== 1'b0) $display("FAIL reset_en_we: got %0b/%0b want 0/0", MemEnable_o, MemWrite_o); else n_pass++;
        n_checks++; if (MemAddr_o !== 32'd0 || MemWdata_o !== 32'd0) $display("FAIL reset_addr_wdata: got %h/%h want 0/0", MemAddr_o, MemWdata_o); else n_pass++;
        n_checks++; if (IRdata_o !== 32'd0 || DRdata_o !== 32'd0) $display("FAIL reset_rdata: got %h/%h want 0/0", IRdata_o, DRdata_o); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            n_checks++; if (StallCycles_o !== 32'd0) $display("FAIL idle_stallcycles[%0d]: got %h want 0", i, StallCycles_o); else n_pass++;
        end
        // stray ack with nothing outstanding
        MemRdata_i = 32'hFFFF_0000;
        MemAck_i   = 1'b1;
        step();
        #1;
        n_checks++; if (IRdata_o !== 32'd0 || DRdata_o !== 32'd0) $display("FAIL idle_ack_rdata: got %h/%h want 0/0", IRdata_o, DRdata_o); else n_pass++;
        n_checks++; if (MemEnable_o !== 1'b0) $display("FAIL idle_ack_en: got %0b want 0", MemEnable_o); else n_pass++;
    endtask

    task automatic test_fetch();
        int stalls, en_cycles;
        step();
        log_n     = 0;
        mem_lat   = 3;
        mem_rdata = 32'h8C02_0004;
        mem_auto  = 1'b1;
        IReq_i    = 1'b1;
        IAddr_i   = 32'h40;
        #1;
        count_stall(50, stalls, en_cycles);
        n_checks++; if (stalls !== 4) $display("FAIL fetch_stall_len: got %0d want 4", stalls); else n_pass++;
        n_checks++; if (log_n !== 1 || log_addr[0] !== 32'h40 || log_we[0] !== 1'b0) $display("FAIL fetch_txn: got n=%0d addr=%h we=%0b want n=1 addr=40 we=0", log_n, log_addr[0], log_we[0]); else n_pass++;
        n_checks++; if (IRdata_o !== 32'h8C02_0004) $display("FAIL fetch_irdata: got %h want 8c020004", IRdata_o); else n_pass++;
        n_checks++; if (StallCycles_o !== 32'd4) $display("FAIL fetch_stallcycles: got %0d want 4", StallCycles_o); else n_pass++;
        step();
        IReq_i = 1'b0;
        #1;
        n_checks++; if (Stall_o !== 1'b0 || MemEnable_o !== 1'b0) $display("FAIL fetch_after: stall=%0b en=%0b want 0/0", Stall_o, MemEnable_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int stalls, en_cycles;
        step();
        log_n     = 0;
        mem_lat   = 1;
        mem_rdata = 32'h0BAD_F00D;
        DWrite_i  = 1'b1;
        DAddr_i   = 32'h100;
        DWdata_i  = 32'hDEAD_BEEF;
        IReq_i    = 1'b1;
        IAddr_i   = 32'h44;
        #1;
        count_stall(50, stalls, en_cycles);
        n_checks++; if (stalls !== 3) $display("FAIL b2b_stall_len: got %0d want 3", stalls); else n_pass++;
        n_checks++; if (en_cycles !== 2) $display("FAIL b2b_enable_cycles: got %0d want 2", en_cycles); else n_pass++;
        n_checks++; if (log_n !== 2) $display("FAIL b2b_txn_count: got %0d want 2", log_n); else n_pass++;
        n_checks++; if (log_addr[0] !== 32'h100 || log_we[0] !== 1'b1 || log_wdata[0] !== 32'hDEAD_BEEF) $display("FAIL b2b_first: got addr=%h we=%0b wd=%h want 100/1/deadbeef", log_addr[0], log_we[0], log_wdata[0]); else n_pass++;
        n_checks++; if (log_addr[1] !== 32'h44 || log_we[1] !== 1'b0) $display("FAIL b2b_second: got addr=%h we=%0b want 44/0", log_addr[1], log_we[1]); else n_pass++;
        n_checks++; if (IRdata_o !== 32'h0BAD_F00D) $display("FAIL b2b_irdata: got %h want 0badf00d", IRdata_o); else n_pass++;
        n_checks++; if (DRdata_o !== 32'd0) $display("FAIL b2b_drdata: got %h want 0", DRdata_o); else n_pass++;
        n_checks++; if (StallCycles_o !== 32'd7) $display("FAIL b2b_stallcycles: got %0d want 7", StallCycles_o); else n_pass++;
        step();
        DWrite_i = 1'b0;
        IReq_i   = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        mem_auto = 1'b0;
        DRead_i  = 1'b1;
        DAddr_i  = 32'h200;
        #1;
        n_checks++; if (Stall_o !== 1'b1) $display("FAIL rstmid_stall0: got %0b want 1", Stall_o); else n_pass++;
        step();
        #1;
        n_checks++; if (MemEnable_o !== 1'b1 || MemAddr_o !== 32'h200) $display("FAIL rstmid_issue: en=%0b addr=%h want 1/200", MemEnable_o, MemAddr_o); else n_pass++;
        Reset_i = 1'b1;
        step();
        Reset_i = 1'b0;
        #1;
        n_checks++; if (MemEnable_o !== 1'b0) $display("FAIL rstmid_en_drop: got %0b want 0", MemEnable_o); else n_pass++;
        n_checks++; if (StallCycles_o !== 32'd0) $display("FAIL rstmid_cnt_clr: got %0d want 0", StallCycles_o); else n_pass++;
        // late ack lands while the arbiter is idle
        MemRdata_i = 32'h1234_5678;
        MemAck_i   = 1'b1;
        mem_rdata  = 32'h1234_5678;
        mem_lat    = 1;
        mem_auto   = 1'b1;
        step();
        #1;
        n_checks++; if (DRdata_o !== 32'd0) $display("FAIL rstmid_late_ack: got %h want 0", DRdata_o); else n_pass++;
        n_checks++; if (MemEnable_o !== 1'b1 || Stall_o !== 1'b1) $display("FAIL rstmid_reissue: en=%0b stall=%0b want 1/1", MemEnable_o, Stall_o); else n_pass++;
        step();
        #1;
        n_checks++; if (DRdata_o !== 32'h1234_5678) $display("FAIL rstmid_drdata: got %h want 12345678", DRdata_o); else n_pass++;
        n_checks++; if (Stall_o !== 1'b0 || StallCycles_o !== 32'd2) $display("FAIL rstmid_done: stall=%0b cnt=%0d want 0/2", Stall_o, StallCycles_o); else n_pass++;
        step();
        DRead_i = 1'b0;
    endtask

    task automatic test_read_write_both();
        int stalls, en_cycles;
        step();
        log_n     = 0;
        mem_lat   = 2;
        mem_rdata = 32'h55AA_55AA;
        DRead_i   = 1'b1;
        DWrite_i  = 1'b1;
        DAddr_i   = 32'h300;
        DWdata_i  = 32'hCAFE_F00D;
        #1;
        count_stall(50, stalls, en_cycles);
        n_checks++; if (stalls !== 3) $display("FAIL rw_stall_len: got %0d want 3", stalls); else n_pass++;
        n_checks++; if (log_n !== 1 || log_addr[0] !== 32'h300 || log_we[0] !== 1'b1 || log_wdata[0] !== 32'hCAFE_F00D) $display("FAIL rw_txn: n=%0d addr=%h we=%0b wd=%h want 1/300/1/cafef00d", log_n, log_addr[0], log_we[0], log_wdata[0]); else n_pass++;
        n_checks++; if (DRdata_o !== 32'h1234_5678) $display("FAIL rw_drdata: got %h want 12345678", DRdata_o); else n_pass++;
        n_checks++; if (StallCycles_o !== 32'd5) $display("FAIL rw_stallcycles: got %0d want 5", StallCycles_o); else n_pass++;
        step();
        DRead_i  = 1'b0;
        DWrite_i = 1'b0;
    endtask

    task automatic test_saturate();
        int stalls, en_cycles;
        step();
        force dut.r_stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cycles;
        n_checks++; if (StallCycles_o !== 32'hFFFF_FFFE) $display("FAIL sat_preload: got %h want fffffffe", StallCycles_o); else n_pass++;
        step();
        mem_lat   = 4;
        mem_rdata = 32'h0102_0304;
        IReq_i    = 1'b1;
        IAddr_i   = 32'h48;
        #1;
        count_stall(50, stalls, en_cycles);
        n_checks++; if (stalls !== 5) $display("FAIL sat_stall_len: got %0d want 5", stalls); else n_pass++;
        n_checks++; if (StallCycles_o !== 32'hFFFF_FFFF) $display("FAIL sat_value: got %h want ffffffff", StallCycles_o); else n_pass++;
        n_checks++; if (IRdata_o !== 32'h0102_0304) $display("FAIL sat_irdata: got %h want 01020304", IRdata_o); else n_pass++;
        step();
        IReq_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_reset_mid();
        test_read_write_both();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
